// File: rtl/gsr_seq_pkg.sv
// Shared definitions for the GSR/SP power-up sequencer: state encoding,
// counter/index sizing helpers and parameter legality check.
package gsr_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_SETTLE = 2'd1,
    ST_STAGE  = 2'd2,
    ST_RUN    = 2'd3
  } seq_state_e;

  // One counter serves every state, so it is sized for the longest interval.
  function automatic int cnt_width(input int hold_cyc, input int settle_cyc, input int stage_gap);
    int m;
    m = hold_cyc;
    if (settle_cyc > m) m = settle_cyc;
    if (stage_gap > m) m = stage_gap;
    return (m + 1 > 2) ? $clog2(m + 1) : 1;
  endfunction

  function automatic int bank_width(input int n_banks);
    return (n_banks > 1) ? $clog2(n_banks) : 1;
  endfunction

  function automatic bit params_legal(input int hold_cyc, input int settle_cyc,
                                      input int n_banks, input int stage_gap);
    return (hold_cyc >= 1) && (settle_cyc >= 0) && (n_banks >= 1) && (stage_gap >= 1);
  endfunction

endpackage

// File: rtl/gsr_seq_timer.sv
// Shared interval counter for the sequencer: clears to zero, can be frozen,
// and flags when the count equals the terminal value chosen by the current state.
module gsr_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  // Clear wins over hold so a state change always restarts the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/gsr_sp_sequencer.sv
// Power-up / soft-reset sequencer: holds GSRN low, then releases the per-bank
// SP enables as a thermometer, and re-runs the whole sequence on an accepted request.
module gsr_sp_sequencer
  import gsr_seq_pkg::*;
#(
  parameter int HOLD_CYC   = 16,
  parameter int SETTLE_CYC = 4,
  parameter int N_BANKS    = 4,
  parameter int STAGE_GAP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               pause,
  output logic               gsrn,
  output logic [N_BANKS-1:0] sp_en,
  output logic               ack,
  output logic               busy,
  output logic               done
);

  localparam int TW = cnt_width(HOLD_CYC, SETTLE_CYC, STAGE_GAP);
  localparam int BW = bank_width(N_BANKS);
  localparam logic [TW-1:0] HOLD_TERM   = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] SETTLE_TERM = TW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [TW-1:0] GAP_TERM    = TW'(STAGE_GAP - 1);
  localparam logic [BW-1:0] LAST_BANK   = BW'(N_BANKS - 1);

  if (!params_legal(HOLD_CYC, SETTLE_CYC, N_BANKS, STAGE_GAP)) begin : g_bad_params
    $error("gsr_sp_sequencer: HOLD_CYC, N_BANKS and STAGE_GAP must be >= 1, SETTLE_CYC >= 0");
  end

  seq_state_e         state, state_nx;
  logic [BW-1:0]      bank, bank_nx;
  logic [N_BANKS-1:0] sp_en_nx;
  logic               gsrn_nx, ack_nx, busy_nx, done_nx;
  logic               tmr_clr, tmr_hold, tmr_tc;
  logic [TW-1:0]      tmr_term;

  gsr_seq_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .hold (tmr_hold),
    .term (tmr_term),
    .tc   (tmr_tc)
  );

  // Next-state and next-output logic; pause leaves every register untouched except ack.
  always_comb begin
    state_nx = state;
    bank_nx  = bank;
    gsrn_nx  = gsrn;
    sp_en_nx = sp_en;
    ack_nx   = 1'b0;
    busy_nx  = busy;
    done_nx  = done;
    tmr_clr  = 1'b0;
    tmr_hold = 1'b1;
    tmr_term = '0;
    if (!pause) begin
      tmr_hold = 1'b0;
      case (state)
        ST_ASSERT: begin
          tmr_term = HOLD_TERM;
          if (tmr_tc) begin
            state_nx = (SETTLE_CYC == 0) ? ST_STAGE : ST_SETTLE;
            gsrn_nx  = 1'b1;
            tmr_clr  = 1'b1;
          end
        end
        ST_SETTLE: begin
          tmr_term = SETTLE_TERM;
          if (tmr_tc) begin
            state_nx = ST_STAGE;
            tmr_clr  = 1'b1;
          end
        end
        ST_STAGE: begin
          // Bank 0 goes at the end of the first stage cycle, later banks every STAGE_GAP.
          tmr_term = sp_en[0] ? GAP_TERM : '0;
          if (tmr_tc) begin
            sp_en_nx[bank] = 1'b1;
            tmr_clr        = 1'b1;
            if (bank == LAST_BANK) begin
              state_nx = ST_RUN;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
            end else begin
              bank_nx = bank + 1'b1;
            end
          end
        end
        ST_RUN: begin
          tmr_hold = 1'b1;
          if (req) begin
            state_nx = ST_ASSERT;
            bank_nx  = '0;
            gsrn_nx  = 1'b0;
            sp_en_nx = '0;
            ack_nx   = 1'b1;
            busy_nx  = 1'b1;
            done_nx  = 1'b0;
            tmr_clr  = 1'b1;
          end
        end
        default: begin
          state_nx = ST_ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ASSERT;
      bank  <= '0;
      gsrn  <= 1'b0;
      sp_en <= '0;
      ack   <= 1'b0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      bank  <= bank_nx;
      gsrn  <= gsrn_nx;
      sp_en <= sp_en_nx;
      ack   <= ack_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_gsr_sp_sequencer.sv
// Bench for gsr_sp_sequencer: a default-parameter instance and a minimal one
// (1 bank, no settle) run side by side against a timing model plus literal checkpoints.
module tb_gsr_sp_sequencer;

  localparam int H0 = 16, S0 = 4, N0 = 4, G0 = 2;
  localparam int H1 = 1,  S1 = 0, N1 = 1, G1 = 1;
  localparam int T0 = H0 + S0 + 1 + (N0 - 1) * G0;
  localparam int T1 = H1 + S1 + 1 + (N1 - 1) * G1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, pause0 = 1'b0, req1 = 1'b0, pause1 = 1'b0;
  logic gsrn0, ack0, busy0, done0;
  logic gsrn1, ack1, busy1, done1;
  logic [3:0] sp_en0;
  logic [0:0] sp_en1;
  logic [7:0] vec0, vec1;

  int total = 0;
  int bad = 0;
  int cyc = -1;
  int s0 = 0, s1 = 0;
  logic mack0 = 1'b0, mack1 = 1'b0;

  always #5 clk = ~clk;

  gsr_sp_sequencer #(
    .HOLD_CYC(H0), .SETTLE_CYC(S0), .N_BANKS(N0), .STAGE_GAP(G0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .pause(pause0),
    .gsrn(gsrn0), .sp_en(sp_en0), .ack(ack0), .busy(busy0), .done(done0)
  );

  gsr_sp_sequencer #(
    .HOLD_CYC(H1), .SETTLE_CYC(S1), .N_BANKS(N1), .STAGE_GAP(G1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .pause(pause1),
    .gsrn(gsrn1), .sp_en(sp_en1), .ack(ack1), .busy(busy1), .done(done1)
  );

  assign vec0 = {gsrn0, busy0, done0, ack0, sp_en0};
  assign vec1 = {gsrn1, busy1, done1, ack1, 3'b000, sp_en1};

  // Expected {gsrn,busy,done,ack,sp_en} from s = unpaused edges since the sequence began.
  function automatic logic [7:0] expOut(input int s, input int h, input int st,
                                        input int n, input int g, input logic a);
    logic [3:0] sp;
    int t0;
    t0 = h + st + 1;
    sp = '0;
    for (int k = 0; k < n; k++) sp[k] = (s >= t0 + k * g);
    return {(s >= h), !(s >= t0 + (n - 1) * g), (s >= t0 + (n - 1) * g), a, sp};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic p);
    req0   = r;
    pause0 = p;
  endtask

  task automatic goto(input int k);
    int guard = 0;
    while (cyc != k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (cyc != k) begin
      bad++;
      $display("[TB] FAIL goto_timeout: cyc=%0d want %0d", cyc, k);
    end
  endtask

  task automatic lit0(input string name, input int k, input logic [7:0] e);
    goto(k);
    checkOutput(name, vec0, e);
  endtask

  task automatic lit1(input string name, input int k, input logic [7:0] e);
    goto(k);
    checkOutput(name, vec1, e);
  endtask

  // Timing model: a sequence restarts on reset release or on an accepted request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc   = -1;
      s0    = 0;
      s1    = 0;
      mack0 = 1'b0;
      mack1 = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (pause0) mack0 = 1'b0;
      else if (s0 >= T0 && req0) begin mack0 = 1'b1; s0 = 0; end
      else begin mack0 = 1'b0; if (s0 < T0) s0++; end
      if (pause1) mack1 = 1'b0;
      else if (s1 >= T1 && req1) begin mack1 = 1'b1; s1 = 0; end
      else begin mack1 = 1'b0; if (s1 < T1) s1++; end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_dflt", vec0, expOut(s0, H0, S0, N0, G0, mack0));
      checkOutput("model_min", vec1, expOut(s1, H1, S1, N1, G1, mack1));
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: cyc=%0d reached time limit", cyc);
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    req1  = 1'b1;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_dflt", vec0, 8'b0100_0000);
    checkOutput("reset_min", vec1, 8'b0100_0000);
    rst_n = 1'b1;

    lit0("c0_dflt", 0, 8'b0100_0000);
    checkOutput("c0_min", vec1, 8'b1100_0000);
    lit1("min_run", 1, 8'b1010_0001);
    lit1("min_ack1", 2, 8'b0101_0000);
    lit1("min_stage", 3, 8'b1100_0000);
    lit1("min_ack2", 5, 8'b0101_0000);

    lit0("gsrn_low14", 14, 8'b0100_0000);
    lit0("gsrn_rel15", 15, 8'b1100_0000);
    lit0("settle19", 19, 8'b1100_0000);
    lit0("bank0_20", 20, 8'b1100_0001);
    lit0("bank1_22", 22, 8'b1100_0011);
    lit0("bank2_24", 24, 8'b1100_0111);
    lit0("hold25", 25, 8'b1100_0111);
    lit0("run26", 26, 8'b1010_1111);

    goto(28);
    applyStimulus(1'b1, 1'b0);
    lit0("req_ack29", 29, 8'b0101_0000);
    applyStimulus(1'b0, 1'b0);
    lit0("ack_gone30", 30, 8'b0100_0000);

    goto(35);
    applyStimulus(1'b1, 1'b0);
    lit0("req_in_assert", 36, 8'b0100_0000);
    goto(38);
    applyStimulus(1'b0, 1'b0);
    lit0("reseq_gsrn44", 44, 8'b0100_0000);
    lit0("reseq_gsrn45", 45, 8'b1100_0000);
    goto(50);
    checkOutput("reseq_bank0", vec0, 8'b1100_0001);
    applyStimulus(1'b1, 1'b0);
    lit0("req_in_stage", 51, 8'b1100_0001);
    goto(55);
    applyStimulus(1'b0, 1'b0);
    lit0("reseq_run56", 56, 8'b1010_1111);

    goto(58);
    applyStimulus(1'b1, 1'b0);
    lit0("req_ack59", 59, 8'b0101_0000);
    applyStimulus(1'b0, 1'b0);
    goto(80);
    checkOutput("p_bank0", vec0, 8'b1100_0001);
    applyStimulus(1'b0, 1'b1);
    lit0("paused83", 83, 8'b1100_0001);
    goto(85);
    applyStimulus(1'b0, 1'b0);
    lit0("p_hold86", 86, 8'b1100_0001);
    lit0("p_bank1", 87, 8'b1100_0011);
    lit0("p_bank2", 90, 8'b1100_0111);
    lit0("p_run91", 91, 8'b1010_1111);

    goto(93);
    applyStimulus(1'b1, 1'b1);
    lit0("pause_blk94", 94, 8'b1010_1111);
    lit0("pause_blk95", 95, 8'b1010_1111);
    applyStimulus(1'b1, 1'b0);
    lit0("unpause_ack", 96, 8'b0101_0000);
    applyStimulus(1'b0, 1'b0);

    lit0("pre_rst_0011", 120, 8'b1100_0011);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_dflt", vec0, 8'b0100_0000);
    checkOutput("async_rst_min", vec1, 8'b0100_0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lit1("rst_min_run", 1, 8'b1010_0001);
    lit0("rst_gsrn15", 15, 8'b1100_0000);
    lit0("rst_bank0", 20, 8'b1100_0001);
    lit0("rst_run26", 26, 8'b1010_1111);
    goto(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
